// File: rtl/l2_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported L2 block port (I-cache vs D-cache).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed D-cache priority.
module l2_port_arbiter #(
    parameter int BLOCKS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [31:0]            i_addr,
    input  logic                   i_we,
    input  logic [BLOCKS*32-1:0]   i_write_block,
    output logic [BLOCKS*32-1:0]   i_read_block,
    output logic                   i_miss,
    input  logic                   d_req,
    input  logic [31:0]            d_addr,
    input  logic                   d_we,
    input  logic [BLOCKS*32-1:0]   d_write_block,
    output logic [BLOCKS*32-1:0]   d_read_block,
    output logic                   d_miss,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    output logic                   mem_we,
    output logic [BLOCKS*32-1:0]   mem_write_block,
    input  logic [BLOCKS*32-1:0]   mem_read_block,
    input  logic                   mem_miss,
    output logic [1:0]             dbg_state
);
    // Handshake: a cache raises x_req with address/data stable and holds it; x_miss stays
    // high until the cycle its grant completes (mem_req & !mem_miss), then falls in that cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state_q, state_d, tie_state;
    logic   done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_d_q <= 1'b0;
        else       last_d_q <= last_d_d;
    end

    // done can only be high in a grant state, so it alone marks a completion.
    always_comb begin
        last_d_d = last_d_q;
        if (done) last_d_d = (state_q == GNT_D);
    end

    assign tie_state = last_d_q ? GNT_I : GNT_D;
`else
    assign tie_state = GNT_D;
`endif

    always_comb begin
        state_d         = state_q;
        done            = 1'b0;
        mem_req         = 1'b0;
        mem_addr        = 32'd0;
        mem_we          = 1'b0;
        mem_write_block = '0;
        i_read_block    = '0;
        d_read_block    = '0;
        i_miss          = i_req;
        d_miss          = d_req;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) state_d = tie_state;
                else if (d_req)     state_d = GNT_D;
                else if (i_req)     state_d = GNT_I;
            end
            GNT_I: begin
                mem_req         = 1'b1;
                mem_addr        = i_addr;
                mem_we          = i_we;
                mem_write_block = i_write_block;
                i_read_block    = mem_read_block;
                done            = !mem_miss;
                i_miss          = i_req && !done;
                // Completion or an abort both return through IDLE to force the one-cycle gap.
                if (done || !i_req) state_d = IDLE;
            end
            GNT_D: begin
                mem_req         = 1'b1;
                mem_addr        = d_addr;
                mem_we          = d_we;
                mem_write_block = d_write_block;
                d_read_block    = mem_read_block;
                done            = !mem_miss;
                d_miss          = d_req && !done;
                if (done || !d_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level ownership model.
module tb_l2_port_arbiter;
    localparam int BLOCKS = 4;
    localparam int BW     = BLOCKS * 32;

    logic          clock, reset;
    logic          i_req, i_we, d_req, d_we;
    logic [31:0]   i_addr, d_addr;
    logic [BW-1:0] i_write_block, d_write_block;
    logic [BW-1:0] i_read_block, d_read_block;
    logic          i_miss, d_miss;
    logic          mem_req, mem_we, mem_miss;
    logic [31:0]   mem_addr;
    logic [BW-1:0] mem_write_block, mem_read_block;
    logic [1:0]    dbg_state;

    int total, bad;
    int mem_lat, burst;
    bit rand_lat;
    int last_srv;  // 1 = I-cache served last, 2 = D-cache served last

    l2_port_arbiter #(.BLOCKS(BLOCKS)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_write_block(i_write_block),
        .i_read_block(i_read_block), .i_miss(i_miss),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_write_block(d_write_block),
        .d_read_block(d_read_block), .d_miss(d_miss),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_write_block(mem_write_block), .mem_read_block(mem_read_block),
        .mem_miss(mem_miss), .dbg_state(dbg_state)
    );

    function automatic logic [BW-1:0] blk(input logic [31:0] a);
        return {a + 32'd3, a + 32'd2, a + 32'd1, a};
    endfunction

    // Arbitration policy: sole requester wins; a tie goes to D (fixed) or to the one not served last.
    function automatic int pick(input logic ir, input logic dr);
        if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last_srv == 2) ? 1 : 2;
`else
            return 2;
`endif
        end
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: busy for mem_lat cycles of each mem_req burst, then completes.
    assign mem_read_block = mem_req ? blk(mem_addr) : {BLOCKS{32'hdeadbeef}};
    always @(posedge clock) begin
        #1;
        if (mem_req) begin
            burst = burst + 1;
            if (burst == 1 && rand_lat) mem_lat = $urandom_range(0, 4);
        end else begin
            burst = 0;
        end
        mem_miss = mem_req && (burst <= mem_lat);
    end

    task automatic next_cycle;
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h10; i_we = 1'b0; i_write_block = '0;
        d_req = 1'b0; d_addr = 32'd0; d_we = 1'b0; d_write_block = '0;
        next_cycle;
        next_cycle;
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
        total++; if (mem_write_block !== '0) begin bad++; $display("FAIL reset_mem_wblk got=%0h exp=0", mem_write_block); end
        total++; if (i_read_block !== '0 || d_read_block !== '0) begin bad++; $display("FAIL reset_rblk got=%0h/%0h exp=0", i_read_block, d_read_block); end
        total++; if (i_miss !== 1'b1) begin bad++; $display("FAIL reset_i_miss got=%0h exp=1", i_miss); end
        total++; if (d_miss !== 1'b0) begin bad++; $display("FAIL reset_d_miss got=%0h exp=0", d_miss); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0h exp=0", dbg_state); end
        next_cycle;
        reset = 1'b0;
        i_req = 1'b0;
        last_srv = 1;
    endtask

    task automatic test_lone_i_read;
        logic exp_req;
        rand_lat = 1'b0; mem_lat = 3;
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            if (c == 0) begin i_req = 1'b1; i_addr = 32'h40; i_we = 1'b0; end
            if (c == 5) i_req = 1'b0;
            @(negedge clock);
            exp_req = (c >= 1 && c <= 4);
            total++; if (mem_req !== exp_req) begin bad++; $display("FAIL lone_i_mem_req c=%0d got=%0h exp=%0h", c, mem_req, exp_req); end
            total++; if (mem_addr !== (exp_req ? 32'h40 : 32'd0)) begin bad++; $display("FAIL lone_i_mem_addr c=%0d got=%0h", c, mem_addr); end
            total++; if (i_miss !== (c < 4)) begin bad++; $display("FAIL lone_i_miss c=%0d got=%0h exp=%0h", c, i_miss, (c < 4)); end
            total++; if (i_read_block !== (exp_req ? blk(32'h40) : '0)) begin bad++; $display("FAIL lone_i_rblk c=%0d got=%0h", c, i_read_block); end
            total++; if (d_read_block !== '0) begin bad++; $display("FAIL lone_i_d_rblk c=%0d got=%0h exp=0", c, d_read_block); end
        end
        last_srv = 1;
    endtask

    task automatic test_lone_d_write;
        logic          exp_req;
        logic [BW-1:0] wdata;
        rand_lat = 1'b0; mem_lat = 3;
        wdata = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            if (c == 0) begin d_req = 1'b1; d_addr = 32'h100; d_we = 1'b1; d_write_block = wdata; end
            if (c == 5) begin d_req = 1'b0; d_we = 1'b0; end
            @(negedge clock);
            exp_req = (c >= 1 && c <= 4);
            total++; if (mem_req !== exp_req) begin bad++; $display("FAIL lone_d_mem_req c=%0d got=%0h exp=%0h", c, mem_req, exp_req); end
            total++; if (mem_we !== exp_req) begin bad++; $display("FAIL lone_d_mem_we c=%0d got=%0h exp=%0h", c, mem_we, exp_req); end
            total++; if (mem_write_block !== (exp_req ? wdata : '0)) begin bad++; $display("FAIL lone_d_wblk c=%0d got=%0h", c, mem_write_block); end
            total++; if (d_miss !== (c < 4)) begin bad++; $display("FAIL lone_d_miss c=%0d got=%0h exp=%0h", c, d_miss, (c < 4)); end
        end
        last_srv = 2;
    endtask

    task automatic test_tie;
        int          win, lose, own;
        logic [31:0] exp_addr;
        logic        exp_im, exp_dm;
        rand_lat = 1'b0; mem_lat = 3;
        for (int r = 0; r < 2; r++) begin
            win  = pick(1'b1, 1'b1);
            lose = 3 - win;
            // Winner owns cycles 1..4, gap at 5, loser owns 6..9.
            for (int c = 0; c <= 10; c++) begin
                next_cycle;
                if (c == 0) begin
                    i_req = 1'b1; i_addr = 32'h80;  i_we = 1'b0;
                    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0;
                end
                if (c == 5)  begin if (win == 1)  i_req = 1'b0; else d_req = 1'b0; end
                if (c == 10) begin if (lose == 1) i_req = 1'b0; else d_req = 1'b0; end
                @(negedge clock);
                own = (c >= 1 && c <= 4) ? win : (c >= 6 && c <= 9) ? lose : 0;
                exp_addr = (own == 1) ? 32'h80 : (own == 2) ? 32'h200 : 32'd0;
                exp_im = i_req && !(own == 1 && (c == 4 || c == 9));
                exp_dm = d_req && !(own == 2 && (c == 4 || c == 9));
                total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL tie_mem_addr r=%0d c=%0d got=%0h exp=%0h", r, c, mem_addr, exp_addr); end
                total++; if (mem_req !== (own != 0)) begin bad++; $display("FAIL tie_mem_req r=%0d c=%0d got=%0h exp=%0h", r, c, mem_req, (own != 0)); end
                total++; if (i_miss !== exp_im) begin bad++; $display("FAIL tie_i_miss r=%0d c=%0d got=%0h exp=%0h", r, c, i_miss, exp_im); end
                total++; if (d_miss !== exp_dm) begin bad++; $display("FAIL tie_d_miss r=%0d c=%0d got=%0h exp=%0h", r, c, d_miss, exp_dm); end
            end
            last_srv = lose;
        end
    endtask

    task automatic test_late_arrival;
        int          own;
        logic [31:0] exp_addr;
        rand_lat = 1'b0; mem_lat = 3;
        for (int c = 0; c <= 10; c++) begin
            next_cycle;
            if (c == 0)  begin i_req = 1'b1; i_addr = 32'h300; i_we = 1'b0; end
            if (c == 2)  begin d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0; end
            if (c == 5)  i_req = 1'b0;
            if (c == 10) d_req = 1'b0;
            @(negedge clock);
            own = (c >= 1 && c <= 4) ? 1 : (c >= 6 && c <= 9) ? 2 : 0;
            exp_addr = (own == 1) ? 32'h300 : (own == 2) ? 32'h400 : 32'd0;
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL late_mem_addr c=%0d got=%0h exp=%0h", c, mem_addr, exp_addr); end
            total++; if (d_miss !== (d_req && c != 9)) begin bad++; $display("FAIL late_d_miss c=%0d got=%0h exp=%0h", c, d_miss, (d_req && c != 9)); end
            total++; if (i_miss !== (i_req && c != 4)) begin bad++; $display("FAIL late_i_miss c=%0d got=%0h exp=%0h", c, i_miss, (i_req && c != 4)); end
        end
        last_srv = 2;
    endtask

    task automatic test_reset_mid;
        int done_c;
        rand_lat = 1'b0; mem_lat = 5;
        done_c = -1;
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            if (c == 0) begin i_req = 1'b1; i_addr = 32'h500; i_we = 1'b0; end
            if (c == 2) reset = 1'b1;
        end
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_mem_req got=%0h exp=0", mem_req); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0h exp=0", dbg_state); end
        total++; if (i_read_block !== '0) begin bad++; $display("FAIL rstmid_rblk got=%0h exp=0", i_read_block); end
        total++; if (i_miss !== 1'b1) begin bad++; $display("FAIL rstmid_i_miss got=%0h exp=1", i_miss); end
        last_srv = 1;
        for (int c = 3; c < 20 && done_c < 0; c++) begin
            next_cycle;
            if (c == 3) reset = 1'b0;
            @(negedge clock);
            if (c == 4) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin bad++; $display("FAIL rstmid_regrant got=%0h/%0h exp=1/500", mem_req, mem_addr); end
            end
            if (!i_miss) done_c = c;
        end
        total++; if (done_c != 9) begin bad++; $display("FAIL rstmid_done_cycle got=%0d exp=9", done_c); end
        next_cycle;
        i_req = 1'b0;
        next_cycle;
        last_srv = 1;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            next_cycle;
            @(negedge clock);
            total++; if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin bad++; $display("FAIL idle_mem c=%0d got=%0h/%0h exp=0/0", c, mem_req, mem_addr); end
            total++; if (i_miss !== 1'b0 || d_miss !== 1'b0) begin bad++; $display("FAIL idle_miss c=%0d got=%0h/%0h exp=0/0", c, i_miss, d_miss); end
        end
    endtask

    task automatic test_random;
        logic [31:0]   i_exp_q[$];
        logic [31:0]   d_exp_q[$];
        logic [31:0]   a, exp_addr;
        logic [BW-1:0] exp_wb, exp_irb, exp_drb;
        logic          exp_we, exp_im, exp_dm, fin, i_cpl, d_cpl;
        int            m_own, w;
        rand_lat = 1'b1;
        m_own = 0; i_cpl = 1'b0; d_cpl = 1'b0;
        for (int c = 0; c < 420; c++) begin
            next_cycle;
            if (i_cpl) begin i_req = 1'b0; i_cpl = 1'b0; end
            else if (!i_req && c < 360 && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1; i_addr = $urandom; i_we = 1'($urandom_range(0, 1));
                i_write_block = {$urandom, $urandom, $urandom, $urandom};
            end
            if (d_cpl) begin d_req = 1'b0; d_cpl = 1'b0; end
            else if (!d_req && c < 360 && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
                d_write_block = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clock);
            fin      = (m_own != 0) && !mem_miss;
            exp_addr = (m_own == 1) ? i_addr : (m_own == 2) ? d_addr : 32'd0;
            exp_we   = (m_own == 1) ? i_we : (m_own == 2) ? d_we : 1'b0;
            exp_wb   = (m_own == 1) ? i_write_block : (m_own == 2) ? d_write_block : '0;
            exp_irb  = (m_own == 1) ? blk(i_addr) : '0;
            exp_drb  = (m_own == 2) ? blk(d_addr) : '0;
            exp_im   = i_req && !(fin && m_own == 1);
            exp_dm   = d_req && !(fin && m_own == 2);
            total++; if (mem_req !== (m_own != 0)) begin bad++; $display("FAIL rnd_mem_req c=%0d got=%0h exp=%0h", c, mem_req, (m_own != 0)); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL rnd_mem_addr c=%0d got=%0h exp=%0h", c, mem_addr, exp_addr); end
            total++; if (mem_we !== exp_we) begin bad++; $display("FAIL rnd_mem_we c=%0d got=%0h exp=%0h", c, mem_we, exp_we); end
            total++; if (mem_write_block !== exp_wb) begin bad++; $display("FAIL rnd_mem_wblk c=%0d got=%0h exp=%0h", c, mem_write_block, exp_wb); end
            total++; if (i_read_block !== exp_irb) begin bad++; $display("FAIL rnd_i_rblk c=%0d got=%0h exp=%0h", c, i_read_block, exp_irb); end
            total++; if (d_read_block !== exp_drb) begin bad++; $display("FAIL rnd_d_rblk c=%0d got=%0h exp=%0h", c, d_read_block, exp_drb); end
            total++; if (i_miss !== exp_im) begin bad++; $display("FAIL rnd_i_miss c=%0d got=%0h exp=%0h", c, i_miss, exp_im); end
            total++; if (d_miss !== exp_dm) begin bad++; $display("FAIL rnd_d_miss c=%0d got=%0h exp=%0h", c, d_miss, exp_dm); end
            // Requester side: a completion is seen as req high with miss low.
            if (i_req && !i_miss) begin
                i_cpl = 1'b1;
                a = (i_exp_q.size() > 0) ? i_exp_q.pop_front() : 32'hffffffff;
                total++; if (i_read_block !== blk(a)) begin bad++; $display("FAIL rnd_i_data c=%0d got=%0h exp=%0h", c, i_read_block, blk(a)); end
            end
            if (d_req && !d_miss) begin
                d_cpl = 1'b1;
                a = (d_exp_q.size() > 0) ? d_exp_q.pop_front() : 32'hffffffff;
                total++; if (d_read_block !== blk(a)) begin bad++; $display("FAIL rnd_d_data c=%0d got=%0h exp=%0h", c, d_read_block, blk(a)); end
            end
            // Ownership model: owner holds the port until memory completes; a new owner is
            // chosen only in a cycle with no owner, and is granted from the next cycle.
            if (fin) begin
                last_srv = m_own;
                m_own = 0;
            end else if (m_own == 0) begin
                w = pick(i_req, d_req);
                if (w == 1) i_exp_q.push_back(i_addr);
                if (w == 2) d_exp_q.push_back(d_addr);
                m_own = w;
            end
        end
        total++; if (i_req !== 1'b0 || d_req !== 1'b0 || i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            bad++; $display("FAIL rnd_drain got=%0h/%0h/%0d/%0d exp=0/0/0/0", i_req, d_req, i_exp_q.size(), d_exp_q.size());
        end
    endtask

    initial begin
        total = 0; bad = 0;
        mem_lat = 3; burst = 0; rand_lat = 1'b0; mem_miss = 1'b1;
        last_srv = 1;
        test_reset;
        test_lone_i_read;
        test_lone_d_write;
        test_tie;
        test_late_arrival;
        test_reset_mid;
        test_idle;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
